// File: rtl/adder_four_imm_mux32_if.sv
// PC datapath bundle: stimulus (start PC, branch offset, select) and the
// registered/combinational PC results.
interface adder_four_imm_mux32_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] startPC;
  logic [WIDTH-1:0] imm32;
  logic             PCSel;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] pc0;
  logic [WIDTH-1:0] pc1;
  logic [WIDTH-1:0] next_pc;
  logic             c0;
  logic             c1;

  // Side that drives the PC unit (fetch control)
  modport master (
    output startPC, imm32, PCSel,
    input  PC, pc0, pc1, next_pc, c0, c1
  );

  // The PC unit itself
  modport slave (
    input  startPC, imm32, PCSel,
    output PC, pc0, pc1, next_pc, c0, c1
  );
endinterface

// File: rtl/adder_four_imm_mux32.sv
// Program counter with sequential (+INCR) and offset (+imm32) targets,
// a 2:1 target select and a falling-edge PC register.
module adder_four_imm_mux32 #(
  parameter int WIDTH = 32,
  parameter int INCR  = 4
) (
  input  logic                  CLK,
  input  logic                  MasterReset,
  adder_four_imm_mux32_if.slave bus
);
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_next;

  // NOTE: a declaration initializer (not a reset) gives the power-up value;
  // MasterReset deliberately never clears this flag.
  logic initialized = 1'b0;

  AdderFour #(.WIDTH(WIDTH), .INCR(INCR)) u_adder_four (
    .a     (pc_q),
    .sum   (bus.pc0),
    .carry (bus.c0)
  );

  AdderImm #(.WIDTH(WIDTH)) u_adder_imm (
    .a        (pc_q),
    .b        (bus.imm32),
    .sum      (bus.pc1),
    .overflow (bus.c1)
  );

  MUX32_2to1 #(.WIDTH(WIDTH)) u_mux (
    .in0 (bus.pc0),
    .in1 (bus.pc1),
    .sel (bus.PCSel),
    .out (pc_next)
  );

  // NOTE: state registers use non-blocking assignment; this design is
  // clocked on the falling edge of CLK.
  always_ff @(negedge CLK) begin
    if (!initialized || MasterReset) begin
      pc_q <= bus.startPC;
    end else begin
      pc_q <= pc_next;
    end
    initialized <= 1'b1;
  end

  assign bus.PC      = pc_q;
  assign bus.next_pc = pc_next;
endmodule

// Sequential target: PC + INCR with unsigned carry-out.
module AdderFour #(
  parameter int WIDTH = 32,
  parameter int INCR  = 4
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  logic [WIDTH:0] wide;

  assign wide  = {1'b0, a} + (WIDTH+1)'(INCR);
  assign sum   = wide[WIDTH-1:0];
  assign carry = wide[WIDTH];
endmodule

// Offset target: PC + signed offset, flagging two's-complement overflow.
module AdderImm #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);
  assign sum      = a + b;
  assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// 2:1 select; a defined sel never lets the unselected input leak through.
module MUX32_2to1 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);
  assign out = sel ? in1 : in0;
endmodule

// File: tb/tb_adder_four_imm_mux32.sv
// Scoreboard bench for adder_four_imm_mux32: expected PC values are queued
// when inputs are driven and compared after each falling CLK edge.
module tb_adder_four_imm_mux32;
  localparam int WIDTH = 32;
  localparam int INCR  = 4;

  logic CLK = 1'b0;
  logic MasterReset;

  adder_four_imm_mux32_if #(.WIDTH(WIDTH)) bus ();

  adder_four_imm_mux32 #(.WIDTH(WIDTH), .INCR(INCR)) dut (
    .CLK         (CLK),
    .MasterReset (MasterReset),
    .bus         (bus.slave)
  );

  always #5 CLK = ~CLK;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_pc;
  bit          model_init = 1'b0;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, check combinational outputs, queue the
  // expected PC, then compare after the falling edge.
  task automatic cycle(input logic rst, input logic [31:0] start,
                       input logic [31:0] imm, input logic sel, input string tag);
    logic [32:0]  seq_sum;
    logic [31:0]  off_sum;
    longint       s_sum;
    logic         ovf;
    logic [31:0]  exp_pc;
    logic [31:0]  got;
    @(posedge CLK);
    #1;
    MasterReset  = rst;
    bus.startPC  = start;
    bus.imm32    = imm;
    bus.PCSel    = sel;
    #1;
    seq_sum = {1'b0, model_pc} + 33'd4;
    off_sum = model_pc + imm;
    s_sum   = longint'($signed(model_pc)) + longint'($signed(imm));
    ovf     = (s_sum > 64'sd2147483647) || (s_sum < -64'sd2147483648);
    if (model_init) begin
      check({tag, ".pc0"}, 64'(bus.pc0), 64'(seq_sum[31:0]));
      check({tag, ".c0"},  64'(bus.c0),  64'(seq_sum[32]));
      check({tag, ".pc1"}, 64'(bus.pc1), 64'(off_sum));
      check({tag, ".c1"},  64'(bus.c1),  64'(ovf));
      if (!rst)
        check({tag, ".next_pc"}, 64'(bus.next_pc), sel ? 64'(off_sum) : 64'(seq_sum[31:0]));
    end
    if (!model_init || rst) exp_pc = start;
    else if (sel)           exp_pc = off_sum;
    else                    exp_pc = seq_sum[31:0];
    exp_q.push_back(exp_pc);
    @(negedge CLK);
    #1;
    got = bus.PC;
    if (exp_q.size() == 0) begin
      check({tag, ".queue_empty"}, 64'd1, 64'd0);
    end else begin
      check({tag, ".PC"}, 64'(got), 64'(exp_q.pop_front()));
    end
    model_pc   = exp_pc;
    model_init = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    MasterReset = 1'b0;
    bus.startPC = 32'h1000;
    bus.imm32   = 32'h0;
    bus.PCSel   = 1'b0;
    model_pc    = 32'h0;

    // Power-up load without reset, then sequential stepping
    cycle(1'b0, 32'h1000, 32'h0, 1'b0, "powerup");
    cycle(1'b0, 32'h1000, 32'h0, 1'b0, "seq1");
    cycle(1'b0, 32'h1000, 32'h0, 1'b0, "seq2");
    check("seq2.value", 64'(bus.PC), 64'h1008);

    // Branch then return to sequential
    cycle(1'b0, 32'h1000, 32'h20, 1'b1, "branch");
    check("branch.value", 64'(bus.PC), 64'h1028);
    cycle(1'b0, 32'h1000, 32'h20, 1'b0, "after_branch");
    check("after_branch.value", 64'(bus.PC), 64'h102C);

    // Negative offset
    cycle(1'b1, 32'h100, 32'h0, 1'b0, "load_100");
    check("neg.pc1", 64'(bus.pc1), 64'h100);
    cycle(1'b0, 32'h0, 32'hFFFF_FFF0, 1'b1, "neg_offset");
    check("neg.value", 64'(bus.PC), 64'hF0);

    // Wraparound of the sequential adder
    cycle(1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0, "load_wrap");
    cycle(1'b0, 32'h0, 32'h0, 1'b0, "wrap");
    check("wrap.value", 64'(bus.PC), 64'h0);

    // Reset overrides a pending branch; held reset tracks startPC
    cycle(1'b1, 32'h2000, 32'h0, 1'b0, "load_2000");
    cycle(1'b1, 32'h500, 32'h40, 1'b1, "rst_priority");
    check("rst_priority.value", 64'(bus.PC), 64'h500);
    cycle(1'b1, 32'h600, 32'h40, 1'b1, "rst_track");
    cycle(1'b1, 32'h500, 32'h40, 1'b1, "rst_track2");
    cycle(1'b0, 32'h500, 32'h0, 1'b0, "rst_release");
    check("rst_release.value", 64'(bus.PC), 64'h504);

    // Signed overflow of the offset adder
    cycle(1'b1, 32'h7FFF_FFF0, 32'h0, 1'b0, "load_ovf");
    cycle(1'b0, 32'h0, 32'h20, 1'b1, "overflow");
    check("overflow.value", 64'(bus.PC), 64'h8000_0010);
    cycle(1'b0, 32'h0, 32'h8000_0000, 1'b1, "neg_overflow");

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      cycle(($urandom_range(0, 7) == 0), $urandom, $urandom,
            1'($urandom_range(0, 1)), "random");
    end

    if (exp_q.size() != 0) check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
